// File: rtl/sq_rd_arbiter.sv
// sq_rd_arbiter: round-robin sharing of one sq_rd/cq_rd pair among N_REQ requesters,
// with a per-requester cap on outstanding reads and completion routing by dest tag.
module sq_rd_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_OUTS   = 8,
    parameter int VADDR_BITS = 48,
    parameter int LEN_BITS   = 28,
    parameter int DEST_BITS  = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*VADDR_BITS-1:0]   req_vaddr,
    input  logic [N_REQ*LEN_BITS-1:0]     req_len,
    input  logic [N_REQ-1:0]              req_last,
    output logic                          sq_valid,
    input  logic                          sq_ready,
    output logic [VADDR_BITS-1:0]         sq_vaddr,
    output logic [LEN_BITS-1:0]           sq_len,
    output logic                          sq_last,
    output logic [DEST_BITS-1:0]          sq_dest,
    input  logic                          cq_valid,
    input  logic [DEST_BITS-1:0]          cq_dest,
    output logic [N_REQ-1:0]              cpl_valid,
    output logic [N_REQ*8-1:0]            outs_cnt,
    output logic                          err_cpl
);
    localparam int IW = $clog2(N_REQ);

    logic [7:0]            cnt_q [N_REQ];
    logic [7:0]            cnt_d [N_REQ];
    logic [IW-1:0]         ptr_q, ptr_d, gnt;
    logic [N_REQ-1:0]      elig, cpl_q, cpl_d;
    logic                  found, hs, slot_free;
    logic                  sq_valid_q, sq_valid_d, sq_last_q, sq_last_d, err_q, err_d;
    logic [VADDR_BITS-1:0] sq_vaddr_q, sq_vaddr_d;
    logic [LEN_BITS-1:0]   sq_len_q, sq_len_d;
    logic [DEST_BITS-1:0]  sq_dest_q, sq_dest_d;

    always_comb begin
        slot_free = !sq_valid_q || sq_ready;
        found     = 1'b0;
        gnt       = '0;
        for (int i = 0; i < N_REQ; i++)
            elig[i] = req_valid[i] && (cnt_q[i] < 8'(MAX_OUTS));
        // scan farthest-first so the eligible requester nearest to ptr wins
        for (int k = N_REQ - 1; k >= 0; k--)
            if (elig[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                gnt   = IW'((int'(ptr_q) + k) % N_REQ);
            end
        hs        = slot_free && found;
        req_ready = '0;
        if (hs)
            req_ready[gnt] = 1'b1;
        // a completion hitting a zero count is still legal if that requester issues now
        for (int i = 0; i < N_REQ; i++) begin
            cpl_d[i] = cq_valid && (cq_dest == DEST_BITS'(i)) && ((cnt_q[i] != 8'd0) || req_ready[i]);
            cnt_d[i] = cnt_q[i] + 8'(req_ready[i]) - 8'(cpl_d[i]);
        end
        err_d      = err_q || (cq_valid && (cpl_d == '0));
        ptr_d      = hs ? IW'((int'(gnt) + 1) % N_REQ) : ptr_q;
        sq_valid_d = hs ? 1'b1 : (sq_ready ? 1'b0 : sq_valid_q);
        sq_vaddr_d = hs ? req_vaddr[gnt*VADDR_BITS +: VADDR_BITS] : sq_vaddr_q;
        sq_len_d   = hs ? req_len[gnt*LEN_BITS +: LEN_BITS] : sq_len_q;
        sq_last_d  = hs ? req_last[gnt] : sq_last_q;
        sq_dest_d  = hs ? DEST_BITS'(gnt) : sq_dest_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < N_REQ; i++)
                cnt_q[i] <= '0;
            ptr_q      <= '0;
            cpl_q      <= '0;
            err_q      <= 1'b0;
            sq_valid_q <= 1'b0;
            sq_vaddr_q <= '0;
            sq_len_q   <= '0;
            sq_last_q  <= 1'b0;
            sq_dest_q  <= '0;
        end else begin
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            cpl_q      <= cpl_d;
            err_q      <= err_d;
            sq_valid_q <= sq_valid_d;
            sq_vaddr_q <= sq_vaddr_d;
            sq_len_q   <= sq_len_d;
            sq_last_q  <= sq_last_d;
            sq_dest_q  <= sq_dest_d;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
        assign outs_cnt[g*8 +: 8] = cnt_q[g];
    end

    assign sq_valid  = sq_valid_q;
    assign sq_vaddr  = sq_vaddr_q;
    assign sq_len    = sq_len_q;
    assign sq_last   = sq_last_q;
    assign sq_dest   = sq_dest_q;
    assign cpl_valid = cpl_q;
    assign err_cpl   = err_q;
endmodule

// File: tb/tb_sq_rd_arbiter.sv
// tb_sq_rd_arbiter: directed stimulus with a scoreboard; a negedge monitor pops expected
// sq descriptors and completion pulses whenever the DUT presents them.
module tb_sq_rd_arbiter;
    logic         aclk = 1'b0;
    logic         areset;
    logic [3:0]   req_valid, req_ready, req_last, cpl_valid;
    logic [191:0] req_vaddr;
    logic [111:0] req_len;
    logic         sq_valid, sq_ready, sq_last, cq_valid, err_cpl;
    logic [47:0]  sq_vaddr;
    logic [27:0]  sq_len;
    logic [3:0]   sq_dest, cq_dest;
    logic [31:0]  outs_cnt;

    typedef struct packed {
        logic [3:0]  d;
        logic [47:0] va;
        logic [27:0] ln;
        logic        l;
    } sq_t;

    sq_t        exp_sq[$];
    logic [3:0] exp_cpl[$];
    int         checks = 0;
    int         errors = 0;

    sq_rd_arbiter dut (
        .aclk(aclk), .areset(areset),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_len(req_len), .req_last(req_last),
        .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_vaddr(sq_vaddr), .sq_len(sq_len),
        .sq_last(sq_last), .sq_dest(sq_dest),
        .cq_valid(cq_valid), .cq_dest(cq_dest),
        .cpl_valid(cpl_valid), .outs_cnt(outs_cnt), .err_cpl(err_cpl)
    );

    always #5 aclk = ~aclk;

    function automatic logic [47:0] va(input int i);
        return 48'h1000_0000 + 48'(i) * 48'h100;
    endfunction

    function automatic logic [27:0] ln(input int i);
        return 28'(16 + i);
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sq(input int i);
        exp_sq.push_back({4'(i), va(i), ln(i), i[0]});
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        areset    = 1'b1;
        req_valid = '0;
        cq_valid  = 1'b0;
        sq_ready  = 1'b0;
        cyc();
        cyc();
        areset = 1'b0;
    endtask

    always @(negedge aclk) begin
        if (!areset && sq_valid && sq_ready) begin
            if (exp_sq.size() == 0) chk("sq_unexpected", {sq_dest, sq_vaddr, sq_len, sq_last}, '0);
            else chk("sq_desc", {sq_dest, sq_vaddr, sq_len, sq_last}, exp_sq.pop_front());
        end
        if (!areset && cpl_valid != 4'b0) begin
            if (exp_cpl.size() == 0) chk("cpl_unexpected", 80'(cpl_valid), 80'd0);
            else chk("cpl_valid", 80'(cpl_valid), 80'(exp_cpl.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        areset    = 1'b1;
        req_valid = '0;
        cq_valid  = 1'b0;
        cq_dest   = '0;
        sq_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_vaddr[i*48 +: 48] = va(i);
            req_len[i*28 +: 28]   = ln(i);
            req_last[i]           = i[0];
        end
        cyc();
        cyc();
        chk("rst_sq_valid", 80'(sq_valid), 80'd0);
        chk("rst_sq_data", {sq_dest, sq_vaddr, sq_len, sq_last}, '0);
        chk("rst_cnt", 80'(outs_cnt), 80'd0);
        chk("rst_err", 80'(err_cpl), 80'd0);
        chk("rst_cpl", 80'(cpl_valid), 80'd0);
        areset = 1'b0;
        cyc();
        chk("idle_ready", 80'(req_ready), 80'd0);

        // single request from requester 1
        req_vaddr[48 +: 48] = 48'h1000;
        req_len[28 +: 28]   = 28'd64;
        req_last[1]         = 1'b1;
        sq_ready            = 1'b1;
        req_valid           = 4'b0010;
        exp_sq.push_back({4'd1, 48'h1000, 28'd64, 1'b1});
        #1 chk("t1_ready", 80'(req_ready), 80'b0010);
        cyc();
        req_valid = '0;
        chk("t1_sq_valid", 80'(sq_valid), 80'd1);
        chk("t1_sq_dest", 80'(sq_dest), 80'd1);
        chk("t1_cnt1", 80'(outs_cnt[15:8]), 80'd1);
        cyc();
        chk("t1_drain", 80'(sq_valid), 80'd0);
        req_vaddr[48 +: 48] = va(1);
        req_len[28 +: 28]   = ln(1);
        req_last[1]         = 1'b1;

        // all four requesters continuously valid
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            push_sq(n % 4);
            #1 chk("t2_rr_ready", 80'(req_ready), 80'(4'b0001 << (n % 4)));
            cyc();
        end
        req_valid = '0;
        chk("t2_cnt", 80'(outs_cnt), 80'h02020202);
        cyc();

        // hold with sq_ready low
        sq_ready  = 1'b0;
        req_valid = 4'b0111;
        push_sq(0);
        #1 chk("t3_first", 80'(req_ready), 80'b0001);
        for (int n = 0; n < 5; n++) begin
            cyc();
            chk("t3_hold_ready", 80'(req_ready), 80'd0);
            chk("t3_hold_sq", {sq_valid, sq_dest, sq_vaddr, sq_len}, {1'b1, 4'd0, va(0), ln(0)});
        end
        sq_ready = 1'b1;
        push_sq(1);
        #1 chk("t3_next1", 80'(req_ready), 80'b0010);
        cyc();
        push_sq(2);
        chk("t3_next2", 80'(req_ready), 80'b0100);
        cyc();
        req_valid = '0;
        chk("t3_cnt", 80'(outs_cnt), 80'h02030303);
        cyc();

        // credit cap on requester 2
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'b0100;
        for (int n = 0; n < 8; n++) begin
            push_sq(2);
            cyc();
        end
        chk("t4_cnt_max", 80'(outs_cnt[23:16]), 80'd8);
        chk("t4_capped", 80'(req_ready), 80'd0);
        req_valid = 4'b0101;
        push_sq(0);
        #1 chk("t4_other", 80'(req_ready), 80'b0001);
        cyc();
        req_valid = 4'b0100;
        cq_valid  = 1'b1;
        cq_dest   = 4'd2;
        exp_cpl.push_back(4'b0100);
        #1 chk("t4_still_capped", 80'(req_ready), 80'd0);
        cyc();
        cq_valid = 1'b0;
        chk("t4_cnt_dec", 80'(outs_cnt[23:16]), 80'd7);
        push_sq(2);
        #1 chk("t4_reaccept", 80'(req_ready), 80'b0100);
        cyc();
        req_valid = '0;
        chk("t4_cnt_back", 80'(outs_cnt[23:16]), 80'd8);
        chk("t4_err", 80'(err_cpl), 80'd0);
        cyc();

        // simultaneous issue and completion for requester 0 at count 3
        do_reset();
        sq_ready  = 1'b1;
        req_valid = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            push_sq(0);
            cyc();
        end
        chk("t5_cnt3", 80'(outs_cnt[7:0]), 80'd3);
        cq_valid = 1'b1;
        cq_dest  = 4'd0;
        push_sq(0);
        exp_cpl.push_back(4'b0001);
        #1 chk("t5_ready", 80'(req_ready), 80'b0001);
        cyc();
        req_valid = '0;
        cq_valid  = 1'b0;
        chk("t5_cnt_same", 80'(outs_cnt[7:0]), 80'd3);
        cyc();

        // spurious completions
        do_reset();
        cq_valid = 1'b1;
        cq_dest  = 4'd1;
        cyc();
        cq_valid = 1'b0;
        chk("t6_err_zero", 80'(err_cpl), 80'd1);
        chk("t6_cnt", 80'(outs_cnt), 80'd0);
        cyc();
        cyc();
        chk("t6_err_sticky", 80'(err_cpl), 80'd1);
        do_reset();
        chk("t6_err_clear", 80'(err_cpl), 80'd0);
        cq_valid = 1'b1;
        cq_dest  = 4'd5;
        cyc();
        cq_valid = 1'b0;
        chk("t6_err_range", 80'(err_cpl), 80'd1);

        // reset mid-operation drops pending descriptor; late completion is an error
        do_reset();
        sq_ready  = 1'b0;
        req_valid = 4'b1000;
        cyc();
        req_valid = '0;
        chk("t7_pending", {sq_valid, outs_cnt}, {1'b1, 32'h01000000});
        areset = 1'b1;
        cyc();
        areset = 1'b0;
        chk("t7_dropped", {sq_valid, outs_cnt}, {1'b0, 32'h0});
        cq_valid = 1'b1;
        cq_dest  = 4'd3;
        cyc();
        cq_valid = 1'b0;
        chk("t7_late_err", 80'(err_cpl), 80'd1);
        cyc();
        cyc();

        chk("sq_queue_empty", 80'(exp_sq.size()), 80'd0);
        chk("cpl_queue_empty", 80'(exp_cpl.size()), 80'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sq_rd_arbiter.md
Name: sq_rd_arbiter

Overview:
- Shares the single user-logic read-descriptor queue (sq_rd) and its completion queue (cq_rd) among N_REQ internal requesters inside a vFPGA user region.
- Arbitrates requests round-robin and enforces a per-requester cap on outstanding reads.
- Stamps each issued descriptor with the requester index in the dest field.
- Routes each cq_rd completion back to the originating requester and returns its credit.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- MAX_OUTS, 8, maximum outstanding reads per requester (1..255)
- VADDR_BITS, 48, virtual address width
- LEN_BITS, 28, transfer length width
- DEST_BITS, 4, width of the dest/tag field; must satisfy 2^DEST_BITS >= N_REQ

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  per-requester descriptor valid
- req_ready  out  N_REQ  per-requester descriptor accept
- req_vaddr  in  N_REQ*VADDR_BITS  per-requester virtual address, packed, requester i at slice i
- req_len  in  N_REQ*LEN_BITS  per-requester length
- req_last  in  N_REQ  per-requester last flag
- sq_valid  out  1  issued descriptor valid
- sq_ready  in  1  downstream accept
- sq_vaddr  out  VADDR_BITS  issued address
- sq_len  out  LEN_BITS  issued length
- sq_last  out  1  issued last flag
- sq_dest  out  DEST_BITS  requester index
- cq_valid  in  1  completion valid; always accepted, no ready
- cq_dest  in  DEST_BITS  completion tag
- cpl_valid  out  N_REQ  one-cycle completion pulse per requester
- outs_cnt  out  N_REQ*8  per-requester outstanding count, zero-extended
- err_cpl  out  1  sticky: completion with no matching outstanding request

Behaviour:
- Reset (areset high at a rising aclk edge):
  - sq_valid=0; sq_vaddr/len/last/dest=0; req_ready=0; cpl_valid=0; err_cpl=0.
  - All outstanding counters=0; round-robin pointer=0.
- Output stage: a single registered slot.
  - The slot is free when sq_valid=0 or (sq_valid and sq_ready).
- Eligibility: requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_OUTS.
- Arbitration:
  - Each cycle the slot is free, the first eligible requester is granted, searching i = ptr, ptr+1, ..., wrapping modulo N_REQ.
  - req_ready[grant]=1 combinationally in that cycle; all other req_ready bits are 0.
  - req_ready is never asserted when the slot is not free or no requester is eligible.
- Issue:
  - On handshake (req_valid[g] and req_ready[g]), the next edge loads the slot with requester g's vaddr/len/last, sets sq_dest=g and sq_valid=1, and sets ptr=(g+1) mod N_REQ.
  - Latency is 1 cycle from request handshake to sq_valid.
  - Back-to-back issue at 1 descriptor per cycle while sq_ready=1.
- Hold: while sq_valid=1 and sq_ready=0, all sq_* outputs hold stable and no new grant is made.
- Drain: on sq_valid and sq_ready with no new handshake, sq_valid goes to 0 at the next edge.
- Credit accounting, per requester:
  - +1 on request handshake; -1 on cq_valid with cq_dest=i; unchanged when both occur in the same cycle.
  - The counter never exceeds MAX_OUTS.
  - Credit is consumed at handshake, not at sq acceptance.
- Completion routing:
  - cq_valid with cq_dest=d < N_REQ and cnt[d] > 0: cpl_valid[d]=1 for exactly the next cycle (registered, 1-cycle latency), and cnt[d] decrements.
  - cq_dest >= N_REQ, or cnt[d]=0 with no simultaneous issue to d: no pulse, no counter change, err_cpl set until reset.
  - cnt[d]=0 with a simultaneous handshake for d: treated as valid; pulse generated, count stays 0.
- Wrap-around: ptr wraps from N_REQ-1 to 0; starvation-free, since each eligible requester is served within N_REQ grants.
- Reset mid-operation: any pending sq descriptor is dropped (sq_valid=0 next cycle), counters are cleared, and late completions after reset raise err_cpl.
- outs_cnt mirrors the registered counters.

Test Plan:
- Reset, then requester 1 alone sends vaddr=0x1000, len=64, last=1 with sq_ready=1 -> req_ready[1]=1 the same cycle; next cycle sq_valid=1, sq_dest=1, sq_vaddr=0x1000, sq_len=64; outs_cnt[1]=1.
- All 4 requesters valid continuously, sq_ready=1 -> grant order 0,1,2,3,0,... and one sq_valid per cycle with sq_dest cycling 0..3.
- sq_ready=0 for 5 cycles with a descriptor pending -> sq_* held constant, all req_ready=0; after sq_ready=1, the next grant goes to the requester following the held one.
- MAX_OUTS=8, requester 2 issues 8 with no completions -> req_ready[2] stays 0 while valid and others are still served; cq_valid with cq_dest=2 -> cpl_valid[2] pulses 1 cycle, count 7, next request from 2 accepted.
- Same-cycle issue and completion for requester 0 at count 3 -> count remains 3 and cpl_valid[0] pulses.
- cq_valid with cq_dest=5 (N_REQ=4), or cq_dest=1 with count 0 -> no cpl pulse, err_cpl=1 until areset.
